maxnet_controller: RTL and testbench

//  - Control FSM that sequences the 4-neuron Maxnet winner-take-all datapath.
//  - On a start rising edge it loads X1..X4 into the datapath.
//  - It then repeats the mutual-inhibition update until at most one neuron is nonzero, and raises done.
//  - Sits between the top-level start/done handshake and the datapath load/update enables.

---
 rtl/maxnet_controller.sv | 131 +++++++++++++
 tb/tb_maxnet_controller.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/maxnet_controller.sv
// Sequences the 4-neuron Maxnet datapath: load on start edge, iterate inhibition until <=1 neuron is nonzero.
// Latency: done first high 3+2N cycles after the start edge (N = updates); start edges outside IDLE/DONE ignored.
// Handshake: level start (edge-detected), done held until the next start edge; MAXNET_ITER_LIMIT_EN adds an iteration cap.
module maxnet_controller #(
    parameter int N_NEURONS = 4,
    parameter int CNT_W     = 3,
    parameter int ITER_W    = 6,
    parameter int MAX_ITER  = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  nonzero_cnt,
    output logic              ld_init,
    output logic              ld_update,
    output logic              busy,
    output logic              done,
    output logic              zero_win,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_CHECK  = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state;
    logic   start_q;
    logic   start_e;
    logic   cnt_over;
    logic   one_left;

    // The cap must be reachable by iter_cnt or the limited build could never stop.
    if (MAX_ITER > (2 ** ITER_W) - 1) begin : g_cap_range
        $error("MAX_ITER does not fit in iter_cnt");
    end

    assign start_e  = start & ~start_q;
    // Counts above the neuron count are bogus; treat them as "still contested".
    assign cnt_over = nonzero_cnt > CNT_W'(N_NEURONS);
    assign one_left = !cnt_over && (nonzero_cnt <= CNT_W'(1));

`ifdef MAXNET_ITER_LIMIT_EN
    logic cap_hit;
    assign cap_hit = (iter_cnt == ITER_W'(MAX_ITER));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            start_q   <= 1'b0;
            iter_cnt  <= '0;
            ld_init   <= 1'b0;
            ld_update <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            zero_win  <= 1'b0;
            err       <= 1'b0;
        end else begin
            start_q   <= start;
            ld_init   <= 1'b0;
            ld_update <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    zero_win <= 1'b0;
                    err      <= 1'b0;
                    if (start_e) begin
                        state    <= S_LOAD;
                        iter_cnt <= '0;
                        ld_init  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (one_left) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        zero_win <= (nonzero_cnt == '0);
                    end
`ifdef MAXNET_ITER_LIMIT_EN
                    else if (cap_hit) begin
                        state    <= S_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        zero_win <= 1'b0;
                        err      <= 1'b1;
                    end
`endif
                    else begin
                        state     <= S_UPDATE;
                        ld_update <= 1'b1;
                    end
                end
                S_UPDATE: begin
                    state <= S_CHECK;
                    if (iter_cnt != '1)
                        iter_cnt <= iter_cnt + 1'b1;
                end
                S_DONE: begin
                    if (start_e) begin
                        state    <= S_LOAD;
                        done     <= 1'b0;
                        zero_win <= 1'b0;
                        err      <= 1'b0;
                        iter_cnt <= '0;
                        ld_init  <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    zero_win <= 1'b0;
                    err      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxnet_controller.sv
// Directed bench for maxnet_controller: a sequence-driven datapath model feeds nonzero_cnt,
// expected run results are queued at each launch and checked when done rises.
module tb_maxnet_controller;

    localparam int ITER_W  = 6;
    localparam int SEQ_LEN = 80;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [2:0]        nonzero_cnt;
    logic              ld_init, ld_update, busy, done, zero_win, err;
    logic [ITER_W-1:0] iter_cnt;

    maxnet_controller #(
        .N_NEURONS(4), .CNT_W(3), .ITER_W(ITER_W), .MAX_ITER(40)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .nonzero_cnt(nonzero_cnt),
        .ld_init(ld_init), .ld_update(ld_update), .busy(busy), .done(done),
        .zero_win(zero_win), .iter_cnt(iter_cnt), .err(err)
    );

    always #20 clk = ~clk;

    // Datapath model: seq[k] is the nonzero count after the k-th update (k=0 right after load).
    logic [2:0] seq [SEQ_LEN];
    int idx = 0;
    int cyc = 0;
    int n_init = 0;
    int n_upd = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ld_init === 1'b1) begin
            idx    <= 0;
            n_init <= n_init + 1;
        end else if (ld_update === 1'b1) begin
            idx   <= idx + 1;
            n_upd <= n_upd + 1;
        end
    end

    always_comb nonzero_cnt = seq[(idx > SEQ_LEN - 1) ? SEQ_LEN - 1 : idx];

    typedef struct {
        int upd;
        int iters;
        bit zw;
        bit er;
        int lat;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    int t_start, snap_init, snap_upd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // n entries of hi, then last for the rest of the run.
    task automatic set_seq(input int n, input int hi, input int last);
        for (int i = 0; i < SEQ_LEN; i++)
            seq[i] = (i < n) ? 3'(hi) : 3'(last);
    endtask

    task automatic launch(input bit push, input int n, input bit zw, input bit er);
        exp_t e;
        if (push) begin
            e.upd   = n;
            e.iters = (n > 63) ? 63 : n;
            e.zw    = zw;
            e.er    = er;
            e.lat   = 3 + 2 * n;
            exp_q.push_back(e);
        end
        snap_init = n_init;
        snap_upd  = n_upd;
        t_start   = cyc;
        start     = 1'b1;
        @(negedge clk);
    endtask

    task automatic finish_run(input string tag);
        exp_t e;
        int k = 0;
        while (done !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        e = exp_q.pop_front();
        check({tag, "_latency"}, 32'(cyc - t_start), 32'(e.lat));
        check({tag, "_iter_cnt"}, 32'(iter_cnt), 32'(e.iters));
        check({tag, "_zero_win"}, 32'(zero_win), 32'(e.zw));
        check({tag, "_err"}, 32'(err), 32'(e.er));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ld_init_cnt"}, 32'(n_init - snap_init), 32'd1);
        check({tag, "_ld_update_cnt"}, 32'(n_upd - snap_upd), 32'(e.upd));
    endtask

    task automatic release_start();
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ld_init"}, 32'(ld_init), 32'd0);
        check({tag, "_ld_update"}, 32'(ld_update), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_zero_win"}, 32'(zero_win), 32'd0);
        check({tag, "_iter_cnt"}, 32'(iter_cnt), 32'd0);
    endtask

    initial begin
        int k;
        rst   = 1'b1;
        start = 1'b0;
        set_seq(0, 0, 0);
        @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        // Inputs 2,7,1,6: all four start nonzero, one drops per update.
        set_seq(1, 4, 1);
        seq[1] = 3'd3;
        seq[2] = 3'd2;
        launch(1'b1, 3, 1'b0, 1'b0);
        check("t2_ld_init_pulse", 32'(ld_init), 32'd1);
        finish_run("t2");
        release_start();

        // Single nonzero input (0,5,0,0): already decided after load.
        set_seq(0, 0, 1);
        launch(1'b1, 0, 1'b0, 1'b0);
        finish_run("t3");
        release_start();

        // Equal inputs (3,3,0,0): both inhibit to zero together.
        set_seq(1, 2, 0);
        launch(1'b1, 1, 1'b1, 1'b0);
        finish_run("t4");
        release_start();

        // Start held high for 50 cycles; out-of-range count 7 must still iterate.
        set_seq(1, 7, 1);
        launch(1'b1, 1, 1'b0, 1'b0);
        finish_run("t5");
        while (cyc - t_start < 50) @(negedge clk);
        check("t5_hold_ld_init_cnt", 32'(n_init - snap_init), 32'd1);
        check("t5_hold_done", 32'(done), 32'd1);
        release_start();
        set_seq(0, 0, 1);
        launch(1'b1, 0, 1'b0, 1'b0);
        check("t5_restart_done_low", 32'(done), 32'd0);
        check("t5_restart_ld_init", 32'(ld_init), 32'd1);
        finish_run("t5r");
        release_start();

        // Reset in the middle of an UPDATE cycle.
        set_seq(SEQ_LEN, 4, 4);
        launch(1'b0, 0, 1'b0, 1'b0);
        k = 0;
        while (ld_update !== 1'b1 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t6_update_seen", 32'(ld_update), 32'd1);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        check_all_zero("t6_rst");
        rst       = 1'b0;
        snap_init = n_init;
        snap_upd  = n_upd;
        repeat (10) @(negedge clk);
        check("t6_no_ld_init", 32'(n_init - snap_init), 32'd0);
        check("t6_no_ld_update", 32'(n_upd - snap_upd), 32'd0);
        check("t6_idle_busy", 32'(busy), 32'd0);

`ifdef MAXNET_ITER_LIMIT_EN
        // Count stuck at 4: the cap stops the run after exactly 40 updates.
        set_seq(SEQ_LEN, 4, 4);
        launch(1'b1, 40, 1'b0, 1'b1);
        finish_run("cap");
        repeat (5) @(negedge clk);
        check("cap_no_more_updates", 32'(n_upd - snap_upd), 32'd40);
        release_start();
`else
        // No cap: 70 updates run to completion and iter_cnt saturates at 63.
        set_seq(70, 4, 1);
        launch(1'b1, 70, 1'b0, 1'b0);
        finish_run("sat");
        release_start();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
